// File: rtl/gpio_loop_test_if.sv
// gpio_loop_test_if
// Purpose: bundles the measurement-window controls, loopback I/O and latched
//          result bus of gpio_loop_test into one connection.
// Signals:
//   TIMER_1S    one-cycle gate pulse that ends the current measurement window
//   EDGE_MODE   edge select: 00 rising, 01 falling, 10 both, 11 disabled
//   PAT_EN      enables the output test pattern
//   GPIO_I      asynchronous loopback inputs (N_CH)
//   GPIO_O      test pattern outputs (N_CH)
//   CNT_FLAT    latched counts, channel i at [i*CNT_W +: CNT_W]
//   SAT_FLAGS   channel counter saturated during the latched window
//   ACTIVE      channel latched a non-zero count
//   VALID       one-cycle pulse when new latched results are available
//   WIN_PARTIAL latched window is the first after reset (partial)
// Modports: master drives controls/inputs, slave is the measurement block.
interface gpio_loop_test_if #(
  parameter int N_CH  = 5,
  parameter int CNT_W = 32
);
  logic                    TIMER_1S;
  logic [1:0]              EDGE_MODE;
  logic                    PAT_EN;
  logic [N_CH-1:0]         GPIO_I;
  logic [N_CH-1:0]         GPIO_O;
  logic [N_CH*CNT_W-1:0]   CNT_FLAT;
  logic [N_CH-1:0]         SAT_FLAGS;
  logic [N_CH-1:0]         ACTIVE;
  logic                    VALID;
  logic                    WIN_PARTIAL;

  modport master (
    output TIMER_1S, EDGE_MODE, PAT_EN, GPIO_I,
    input  GPIO_O, CNT_FLAT, SAT_FLAGS, ACTIVE, VALID, WIN_PARTIAL
  );

  modport slave (
    input  TIMER_1S, EDGE_MODE, PAT_EN, GPIO_I,
    output GPIO_O, CNT_FLAT, SAT_FLAGS, ACTIVE, VALID, WIN_PARTIAL
  );
endinterface

// File: rtl/gpio_loop_test.sv
// gpio_loop_test
// Purpose: GPIO loopback tester. Drives a binary-counter test pattern on
//          GPIO_O and counts qualified edges on each GPIO_I channel over a
//          measurement window closed by TIMER_1S, latching the per-channel
//          counts, saturation flags and activity flags at each window end.
// Ports:
//   CLK    system clock, all logic on rising edge
//   RST_N  asynchronous active-low reset (released synchronously inside)
//   bus    gpio_loop_test_if.slave: TIMER_1S, EDGE_MODE, PAT_EN, GPIO_I in;
//          GPIO_O, CNT_FLAT, SAT_FLAGS, ACTIVE, VALID, WIN_PARTIAL out
// Parameters: N_CH channels (1..32), CNT_W counter width (8..32),
//             SYNC_STG input synchroniser depth (2..4).
module gpio_loop_test #(
  parameter int N_CH     = 5,
  parameter int CNT_W    = 32,
  parameter int SYNC_STG = 3
) (
  input logic              CLK,
  input logic              RST_N,
  gpio_loop_test_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Reset assertion is passed straight through; release is aligned to CLK
  // so no flop sees reset removal near its active edge.
  logic [1:0] rstSync_q;
  logic       rstInt_n;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstInt_n = rstSync_q[1];

  logic [N_CH-1:0]        patCnt_q, patCnt_d;
  logic [N_CH-1:0]        sync_q [SYNC_STG];
  logic [N_CH-1:0]        hist_q;
  logic [N_CH-1:0]        syncOut;
  logic [N_CH-1:0]        riseEv, fallEv, edgeEv;
  logic [CNT_W-1:0]       cnt_q [N_CH];
  logic [CNT_W-1:0]       cnt_d [N_CH];
  logic [N_CH-1:0]        satSticky_q, satSticky_d;
  logic [N_CH*CNT_W-1:0]  cntLatch_q, cntLatch_d;
  logic [N_CH-1:0]        satLatch_q, satLatch_d;
  logic [N_CH-1:0]        active_q, active_d;
  logic                   valid_q, valid_d;
  logic                   winPartial_q, winPartial_d;
  logic                   firstWin_q, firstWin_d;

  // Test pattern: free-running binary counter, so bit i toggles every 2^i
  // cycles; disabling the pattern parks it at zero.
  always_comb begin
    patCnt_d = bus.PAT_EN ? patCnt_q + N_CH'(1) : '0;
  end

  // Edge detection compares the last synchroniser stage with one extra
  // history flop. Both reset to 0, so a low input after reset never looks
  // like an edge.
  always_comb begin
    syncOut = sync_q[SYNC_STG-1];
    riseEv  = syncOut & ~hist_q;
    fallEv  = ~syncOut & hist_q;
    case (bus.EDGE_MODE)
      2'b00:   edgeEv = riseEv;
      2'b01:   edgeEv = fallEv;
      2'b10:   edgeEv = riseEv | fallEv;
      default: edgeEv = '0;
    endcase
  end

  // Window accounting. In a TIMER_1S cycle the running count is latched and
  // the counter restarts with this cycle's event already included, so an
  // event coincident with the gate lands in the new window exactly once.
  // Counters stop at all-ones; an event arriving at all-ones sets the sticky
  // saturation bit instead of wrapping.
  always_comb begin
    cnt_d        = cnt_q;
    satSticky_d  = satSticky_q;
    cntLatch_d   = cntLatch_q;
    satLatch_d   = satLatch_q;
    active_d     = active_q;
    valid_d      = bus.TIMER_1S;
    winPartial_d = winPartial_q;
    firstWin_d   = firstWin_q;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.TIMER_1S) begin
        cntLatch_d[i*CNT_W +: CNT_W] = cnt_q[i];
        satLatch_d[i]                = satSticky_q[i];
        active_d[i]                  = (cnt_q[i] != '0);
        cnt_d[i]                     = edgeEv[i] ? CNT_W'(1) : '0;
        satSticky_d[i]               = 1'b0;
      end else if (edgeEv[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          satSticky_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    if (bus.TIMER_1S) begin
      winPartial_d = firstWin_q;
      firstWin_d   = 1'b0;
    end
  end

  // All state registers. WIN_PARTIAL and the first-window marker come out
  // of reset set, everything else clears.
  always_ff @(posedge CLK or negedge rstInt_n) begin
    if (!rstInt_n) begin
      patCnt_q <= '0;
      for (int s = 0; s < SYNC_STG; s++) begin
        sync_q[s] <= '0;
      end
      hist_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      satSticky_q  <= '0;
      cntLatch_q   <= '0;
      satLatch_q   <= '0;
      active_q     <= '0;
      valid_q      <= 1'b0;
      winPartial_q <= 1'b1;
      firstWin_q   <= 1'b1;
    end else begin
      patCnt_q  <= patCnt_d;
      sync_q[0] <= bus.GPIO_I;
      for (int s = 1; s < SYNC_STG; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      hist_q       <= syncOut;
      cnt_q        <= cnt_d;
      satSticky_q  <= satSticky_d;
      cntLatch_q   <= cntLatch_d;
      satLatch_q   <= satLatch_d;
      active_q     <= active_d;
      valid_q      <= valid_d;
      winPartial_q <= winPartial_d;
      firstWin_q   <= firstWin_d;
    end
  end

  assign bus.GPIO_O      = patCnt_q;
  assign bus.CNT_FLAT    = cntLatch_q;
  assign bus.SAT_FLAGS   = satLatch_q;
  assign bus.ACTIVE      = active_q;
  assign bus.VALID       = valid_q;
  assign bus.WIN_PARTIAL = winPartial_q;

endmodule

// File: tb/tb_gpio_loop_test.sv
// tb_gpio_loop_test
// Purpose: directed self-checking bench for gpio_loop_test. A 5-channel,
//          32-bit instance covers loopback, edge modes, coincident events,
//          mid-window reset, back-to-back gates and pattern enable; a
//          1-channel, 8-bit instance covers counter saturation.
module tb_gpio_loop_test;

  logic CLK;
  logic RST_N;

  logic       timerMain, timerSat;
  logic [1:0] modeMain;
  logic       patMain;
  logic       loopEn;
  logic [4:0] gpioDrv;

  int assertCount;
  int failCount;

  gpio_loop_test_if #(.N_CH(5), .CNT_W(32)) ifm ();
  gpio_loop_test_if #(.N_CH(1), .CNT_W(8))  ifs ();

  assign ifm.TIMER_1S  = timerMain;
  assign ifm.EDGE_MODE = modeMain;
  assign ifm.PAT_EN    = patMain;
  assign ifm.GPIO_I    = loopEn ? ifm.GPIO_O : gpioDrv;

  assign ifs.TIMER_1S  = timerSat;
  assign ifs.EDGE_MODE = 2'b10;
  assign ifs.PAT_EN    = 1'b1;
  assign ifs.GPIO_I    = ifs.GPIO_O;

  gpio_loop_test #(.N_CH(5), .CNT_W(32), .SYNC_STG(3)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (ifm)
  );

  gpio_loop_test #(.N_CH(1), .CNT_W(8), .SYNC_STG(3)) dutSat (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (ifs)
  );

  // 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One-cycle gate pulse on the selected instance; returns in the VALID cycle.
  task automatic timerPulse(input bit sat);
    if (sat) timerSat = 1'b1; else timerMain = 1'b1;
    tick(1);
    timerSat  = 1'b0;
    timerMain = 1'b0;
  endtask

  // One rising edge on channel 0 (high two cycles, low two cycles).
  task automatic risingEdges(input int n);
    for (int k = 0; k < n; k++) begin
      gpioDrv[0] = 1'b1;
      tick(2);
      gpioDrv[0] = 1'b0;
      tick(2);
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    tick(3);
    assertCount++;
    if (ifm.CNT_FLAT !== 160'd0) begin
      failCount++;
      $display("[TB] FAIL reset_cnt: got %0h expected 0", ifm.CNT_FLAT);
    end
    assertCount++;
    if ({ifm.SAT_FLAGS, ifm.ACTIVE, ifm.GPIO_O, ifm.VALID} !== 16'd0) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got %0h expected 0",
               {ifm.SAT_FLAGS, ifm.ACTIVE, ifm.GPIO_O, ifm.VALID});
    end
    assertCount++;
    if (ifm.WIN_PARTIAL !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_partial: got %0b expected 1", ifm.WIN_PARTIAL);
    end
    RST_N = 1'b1;
    tick(4);
  endtask

  task automatic test_loopback;
    int got;
    int exp;
    modeMain = 2'b00;
    loopEn   = 1'b1;
    tick(20);
    timerPulse(1'b0);
    assertCount++;
    if (ifm.VALID !== 1'b1 || ifm.WIN_PARTIAL !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL loop_first_window: got valid=%0b partial=%0b expected 1/1",
               ifm.VALID, ifm.WIN_PARTIAL);
    end
    tick(1023);
    timerPulse(1'b0);
    for (int i = 0; i < 5; i++) begin
      got = int'(ifm.CNT_FLAT[i*32 +: 32]);
      exp = 512 >> i;
      assertCount++;
      if (got < exp - 1 || got > exp + 1) begin
        failCount++;
        $display("[TB] FAIL loop_cnt_ch%0d: got %0d expected %0d", i, got, exp);
      end
    end
    assertCount++;
    if (ifm.WIN_PARTIAL !== 1'b0 || ifm.ACTIVE !== 5'h1F || ifm.VALID !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL loop_flags: got partial=%0b active=%0h valid=%0b expected 0/1f/1",
               ifm.WIN_PARTIAL, ifm.ACTIVE, ifm.VALID);
    end
    tick(1);
    assertCount++;
    if (ifm.VALID !== 1'b0 || ifm.CNT_FLAT[31:0] !== 32'd512) begin
      failCount++;
      $display("[TB] FAIL loop_hold: got valid=%0b cnt0=%0d expected 0/512",
               ifm.VALID, ifm.CNT_FLAT[31:0]);
    end
  endtask

  task automatic test_edge_modes;
    int got;
    modeMain = 2'b10;
    tick(5);
    timerPulse(1'b0);
    tick(1023);
    timerPulse(1'b0);
    got = int'(ifm.CNT_FLAT[31:0]);
    assertCount++;
    if (got < 1023 || got > 1025) begin
      failCount++;
      $display("[TB] FAIL both_ch0: got %0d expected 1024", got);
    end
    got = int'(ifm.CNT_FLAT[63:32]);
    assertCount++;
    if (got < 511 || got > 513) begin
      failCount++;
      $display("[TB] FAIL both_ch1: got %0d expected 512", got);
    end
    modeMain = 2'b11;
    tick(5);
    timerPulse(1'b0);
    tick(1023);
    timerPulse(1'b0);
    assertCount++;
    if (ifm.CNT_FLAT !== 160'd0 || ifm.ACTIVE !== 5'h00) begin
      failCount++;
      $display("[TB] FAIL disabled_mode: got cnt=%0h active=%0h expected 0/0",
               ifm.CNT_FLAT, ifm.ACTIVE);
    end
  endtask

  task automatic test_saturation;
    timerPulse(1'b1);
    tick(399);
    timerPulse(1'b1);
    assertCount++;
    if (ifs.CNT_FLAT !== 8'd255 || ifs.SAT_FLAGS !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL sat_window: got cnt=%0d sat=%0b expected 255/1",
               ifs.CNT_FLAT, ifs.SAT_FLAGS);
    end
    tick(99);
    timerPulse(1'b1);
    assertCount++;
    if (ifs.CNT_FLAT !== 8'd100 || ifs.SAT_FLAGS !== 1'b0 || ifs.ACTIVE !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL sat_next_window: got cnt=%0d sat=%0b active=%0b expected 100/0/1",
               ifs.CNT_FLAT, ifs.SAT_FLAGS, ifs.ACTIVE);
    end
  endtask

  task automatic test_coincident;
    loopEn   = 1'b0;
    gpioDrv  = 5'b0;
    modeMain = 2'b00;
    tick(10);
    timerPulse(1'b0);
    risingEdges(3);
    tick(6);
    gpioDrv[0] = 1'b1;
    tick(3);
    assertCount++;
    if (ifm.VALID !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL coinc_pre_valid: got %0b expected 0", ifm.VALID);
    end
    timerPulse(1'b0);
    assertCount++;
    if (ifm.VALID !== 1'b1 || ifm.CNT_FLAT[31:0] !== 32'd3) begin
      failCount++;
      $display("[TB] FAIL coinc_old_window: got valid=%0b cnt0=%0d expected 1/3",
               ifm.VALID, ifm.CNT_FLAT[31:0]);
    end
    tick(10);
    timerPulse(1'b0);
    assertCount++;
    if (ifm.CNT_FLAT[31:0] !== 32'd1 || ifm.ACTIVE !== 5'h01) begin
      failCount++;
      $display("[TB] FAIL coinc_new_window: got cnt0=%0d active=%0h expected 1/01",
               ifm.CNT_FLAT[31:0], ifm.ACTIVE);
    end
  endtask

  task automatic test_reset_mid_window;
    gpioDrv[0] = 1'b0;
    tick(6);
    timerPulse(1'b0);
    risingEdges(50);
    tick(4);
    RST_N = 1'b0;
    tick(1);
    assertCount++;
    if (ifm.CNT_FLAT !== 160'd0 || ifm.VALID !== 1'b0 || ifm.ACTIVE !== 5'h00) begin
      failCount++;
      $display("[TB] FAIL midreset_outputs: got cnt=%0h valid=%0b active=%0h expected 0/0/0",
               ifm.CNT_FLAT, ifm.VALID, ifm.ACTIVE);
    end
    assertCount++;
    if (ifm.GPIO_O !== 5'h00 || ifm.WIN_PARTIAL !== 1'b1 || ifm.SAT_FLAGS !== 5'h00) begin
      failCount++;
      $display("[TB] FAIL midreset_misc: got gpio=%0h partial=%0b sat=%0h expected 0/1/0",
               ifm.GPIO_O, ifm.WIN_PARTIAL, ifm.SAT_FLAGS);
    end
    tick(2);
    RST_N = 1'b1;
    tick(4);
    risingEdges(7);
    tick(6);
    assertCount++;
    if (ifm.VALID !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_no_valid: got %0b expected 0", ifm.VALID);
    end
    timerPulse(1'b0);
    assertCount++;
    if (ifm.CNT_FLAT[31:0] !== 32'd7 || ifm.WIN_PARTIAL !== 1'b1 || ifm.VALID !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL midreset_first_window: got cnt0=%0d partial=%0b valid=%0b expected 7/1/1",
               ifm.CNT_FLAT[31:0], ifm.WIN_PARTIAL, ifm.VALID);
    end
  endtask

  task automatic test_back_to_back;
    gpioDrv[0] = 1'b1;
    tick(6);
    timerMain = 1'b1;
    tick(1);
    assertCount++;
    if (ifm.VALID !== 1'b1 || ifm.CNT_FLAT[31:0] !== 32'd1 || ifm.WIN_PARTIAL !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_first: got valid=%0b cnt0=%0d partial=%0b expected 1/1/0",
               ifm.VALID, ifm.CNT_FLAT[31:0], ifm.WIN_PARTIAL);
    end
    tick(1);
    timerMain = 1'b0;
    assertCount++;
    if (ifm.VALID !== 1'b1 || ifm.CNT_FLAT[31:0] !== 32'd0 || ifm.ACTIVE !== 5'h00) begin
      failCount++;
      $display("[TB] FAIL b2b_second: got valid=%0b cnt0=%0d active=%0h expected 1/0/0",
               ifm.VALID, ifm.CNT_FLAT[31:0], ifm.ACTIVE);
    end
    tick(1);
    assertCount++;
    if (ifm.VALID !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_valid_drop: got %0b expected 0", ifm.VALID);
    end
  endtask

  task automatic test_pat_en;
    patMain = 1'b1;
    tick(7);
    patMain = 1'b0;
    tick(1);
    assertCount++;
    if (ifm.GPIO_O !== 5'h00) begin
      failCount++;
      $display("[TB] FAIL pat_disable: got %0h expected 0", ifm.GPIO_O);
    end
    tick(3);
    assertCount++;
    if (ifm.GPIO_O !== 5'h00) begin
      failCount++;
      $display("[TB] FAIL pat_hold_zero: got %0h expected 0", ifm.GPIO_O);
    end
    patMain = 1'b1;
    tick(1);
    assertCount++;
    if (ifm.GPIO_O !== 5'h01) begin
      failCount++;
      $display("[TB] FAIL pat_restart1: got %0h expected 1", ifm.GPIO_O);
    end
    tick(2);
    assertCount++;
    if (ifm.GPIO_O !== 5'h03) begin
      failCount++;
      $display("[TB] FAIL pat_restart3: got %0h expected 3", ifm.GPIO_O);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    RST_N     = 1'b0;
    timerMain = 1'b0;
    timerSat  = 1'b0;
    modeMain  = 2'b00;
    patMain   = 1'b1;
    loopEn    = 1'b1;
    gpioDrv   = 5'b0;
    test_reset;
    test_loopback;
    test_edge_modes;
    test_saturation;
    test_coincident;
    test_reset_mid_window;
    test_back_to_back;
    test_pat_en;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/gpio_loop_test.md
GPIO_LOOP_TEST -- requirements
Module: gpio_loop_test

Interface
REQ-001 Parameters SHALL be:
- N_CH, default 5, number of GPIO loopback channels, range 1..32.
- CNT_W, default 32, per-channel edge counter width, range 8..32.
- SYNC_STG, default 3, input synchroniser depth, range 2..4.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK  in  1  single system clock; all logic on its rising edge.
- RST_N  in  1  asynchronous active-low reset; asserts asynchronously, deasserts synchronously to CLK.
- TIMER_1S  in  1  one-cycle gate pulse that ends the current measurement window.
- EDGE_MODE  in  2  edge select: 00 rising, 01 falling, 10 both, 11 counting disabled.
- PAT_EN  in  1  enables the output test pattern.
- GPIO_I  in  N_CH  asynchronous loopback inputs.
- GPIO_O  out  N_CH  test pattern outputs.
- CNT_FLAT  out  N_CH*CNT_W  latched counts; channel i occupies bits [i*CNT_W +: CNT_W].
- SAT_FLAGS  out  N_CH  channel counter saturated during the latched window.
- ACTIVE  out  N_CH  channel latched a count other than zero.
- VALID  out  1  one-cycle pulse when new latched results are available.
- WIN_PARTIAL  out  1  the latched window is the first one after reset and is partial.

Function
REQ-003 The pattern counter SHALL be N_CH bits wide, increment by 1 every CLK while PAT_EN=1, and wrap from all-ones to 0.
REQ-004 GPIO_O[i] SHALL equal pattern counter bit i, so channel i toggles every 2^i cycles.
REQ-005 When PAT_EN=0, the pattern counter SHALL clear to 0 on the next edge and GPIO_O SHALL be all zeros.
REQ-006 Each GPIO_I bit SHALL pass through a SYNC_STG-flop synchroniser, followed by one history flop for edge detection.
REQ-007 A rising edge SHALL be history=0 and synchronised=1; a falling edge SHALL be history=1 and synchronised=0.
REQ-008 Edge qualification: a channel edge event SHALL follow EDGE_MODE, with mode 10 counting both edges and mode 11 producing no events.
REQ-009 The latency from a GPIO_I transition to the counter update SHALL be SYNC_STG+1 cycles, given the input meets setup time.
REQ-010 In cycles without TIMER_1S, each channel counter SHALL increment by 1 per edge event.
REQ-011 Saturation: a counter at 2^CNT_W-1 SHALL hold its value and set the channel's sticky saturation bit; it SHALL never wrap.
REQ-012 In a TIMER_1S cycle, the counter and saturation value SHALL be latched into the CNT_FLAT slice and SAT_FLAGS bit.
REQ-013 In that same TIMER_1S cycle, the counter SHALL load 1 if an edge event is present that cycle, otherwise 0, and the sticky saturation bit SHALL clear; no edge is lost or double counted.
REQ-014 ACTIVE[i] SHALL update together with the latch to (latched count != 0).
REQ-015 VALID SHALL pulse high for exactly one cycle, one cycle after each TIMER_1S; the latched outputs SHALL be stable when VALID is high.
REQ-016 WIN_PARTIAL SHALL be 1 for the results latched by the first TIMER_1S after reset, and 0 for all later windows.
REQ-017 Back-to-back TIMER_1S pulses SHALL each latch; a 1-cycle window SHALL latch a count of 0 or 1.
REQ-018 A change of EDGE_MODE SHALL take effect on edge qualification in the next cycle; counts already accumulated SHALL be kept.
REQ-019 The latched outputs SHALL change only in TIMER_1S cycles or on reset.

Reset
REQ-020 While RST_N=0, all of these SHALL be 0: counters, latches, CNT_FLAT, SAT_FLAGS, ACTIVE, VALID, GPIO_O, the pattern counter, and the synchroniser and history flops.
REQ-021 WIN_PARTIAL SHALL reset to 1, latching the first window as partial.
REQ-022 Reset asserted mid-window SHALL discard the partial counts, and no VALID pulse SHALL occur for the discarded window.
REQ-023 After RST_N deasserts, no spurious edge event SHALL be generated from the reset state of the history flops while GPIO_I=0.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Loopback: N_CH=5, PAT_EN=1, GPIO_I=GPIO_O, mode 00, TIMER_1S every 1024 cycles -> second window latches channel counts 512/256/128/64/32 (±1), WIN_PARTIAL=0, ACTIVE=5'h1F.
- Both-edge mode: mode 10, same setup -> channel 0 latches 1024 (±1); mode 11 -> all counts 0 and ACTIVE=0.
- Saturation: CNT_W=8, channel 0 toggles every cycle, mode 10, window of 400 cycles -> count 255 and SAT_FLAGS[0]=1; the next window of 100 cycles latches 100 and SAT_FLAGS[0]=0.
- Coincident event: an edge event arrives in the TIMER_1S cycle -> the old window excludes it and the new window starts at 1; VALID high one cycle later.
- Reset mid-window: RST_N low for 3 cycles after 50 edges -> all outputs 0; the first following TIMER_1S latches the post-reset count with WIN_PARTIAL=1.
- PAT_EN toggle: PAT_EN=0 -> GPIO_O=0 on the next cycle; re-enable -> pattern restarts from 0.
